conv_result_drain: RTL and testbench
====================================

# conv_result_drain

Result-side partner of the convolution engine: it is the receiver for the engine's `y_waddr` / `y_wdata` / `y_wenable` write port and its `finish` pulse. It captures one output vector of DEPTH signed words into local registers. Once `finish` arrives, it streams the words in address order to the next stage over a valid/ready handshake. It then signals completion and rearms for the next vector.

## Interface
- DW, 8, data width (signed two's complement)
- AW, 2, address width; DEPTH = 2**AW entries
- RELU, 0, 1 = clamp negative words to 0 on output, 0 = pass through

- clk  input  1  clock, all state on rising edge
- xrst  input  1  asynchronous reset, active-high
- y_waddr  input  AW  write address from engine
- y_wdata  input  DW  signed write data from engine
- y_wenable  input  1  write strobe from engine
- conv_finish  input  1  single-cycle end-of-vector pulse from engine
- out_addr  output  AW  index of the word presented
- out_data  output  DW  signed word presented
- out_valid  output  1  out_addr/out_data valid
- out_ready  input  1  downstream accepts
- busy  output  1  high while in DRAIN
- done  output  1  one-cycle pulse after the last word is accepted
- overrun  output  1  sticky error flag

## Operation
- States:
  - FILL (reset state)
  - DRAIN
- FILL:
  - `y_wenable=1` writes `y_wdata` into entry `y_waddr` and sets that entry's written bit.
  - Rewriting an entry overwrites it; the last write wins.
  - `conv_finish=1` moves the block to DRAIN. A write in the same cycle is captured before the transition.
- DRAIN:
  - Presents entries 0, 1, …, DEPTH-1 in order.
  - An entry whose written bit is clear is output as 0.
  - A beat transfers on a clock edge where `out_valid && out_ready`.
  - `out_addr` / `out_data` stay stable while `out_valid && !out_ready`.
  - After the transfer of entry DEPTH-1:
    - `done` pulses.
    - All written bits clear and all entries reset to 0.
    - The state returns to FILL.
- RELU=1: `out_data = (entry < 0) ? 0 : entry`, applied at the output. Storage keeps the raw value.
- No arithmetic widening; widths are DW throughout.
- Errors in DRAIN:
  - `y_wenable=1` or `conv_finish=1` sets `overrun`.
  - The write or finish itself is ignored; storage and sequence are unaffected.
  - `overrun` clears only on reset.
- `out_ready` is ignored outside DRAIN.

## Timing
- Reset values (all asserted asynchronously on `xrst=1`):
  - state FILL
  - all entries and written bits 0
  - `out_addr=0`, `out_data=0`, `out_valid=0`
  - `busy=0`, `done=0`, `overrun=0`
- Write latency: a write sampled at edge k is readable in DRAIN from cycle k+1.
- Entering DRAIN: `conv_finish` sampled at edge k gives `busy=1`, `out_valid=1`, `out_addr=0` from cycle k+1 (all outputs registered).
- Throughput: with `out_ready` held high, one word per cycle, no bubbles. A full vector takes DEPTH cycles from the first `out_valid`.
- Exiting DRAIN: the final transfer at edge m gives, in cycle m+1:
  - `done=1` for exactly one cycle
  - `busy=0`, `out_valid=0`
- The block is in FILL during the `done` cycle. A `y_wenable` or `conv_finish` in that cycle is accepted as FILL traffic.
- Reset mid-DRAIN aborts the stream immediately:
  - `out_valid` drops asynchronously.
  - No `done` pulse.
- `conv_finish` with no prior writes is legal and drains DEPTH zeros.

## Test plan
- Full vector, ready always high: write entries 0..3 = 5, -3, 127, -128, then `conv_finish` → out_addr/out_data sequence (0,5), (1,-3), (2,127), (3,-128) on four consecutive cycles starting the cycle after finish; `done` the next cycle; `overrun=0`.
- Backpressure: same data, `out_ready` low for 3 cycles while entry 1 is presented → (1,-3) held stable for all 4 cycles; sequence and `done` timing otherwise shifted by 3.
- Partial and overwritten writes: write addr 2 = 10, then addr 2 = 20, then finish → outputs 0, 0, 20, 0; after `done`, a second finish with no writes drains 0, 0, 0, 0.
- RELU=1: entries -1, 4, -128, 0 → outputs 0, 4, 0, 0.
- Overrun: during DRAIN of vector 1, write addr 0 = 99 and pulse `conv_finish` → `overrun=1` from the next cycle and stays high; vector 1 output unchanged; block returns to FILL and does not start a second drain.
- Reset mid-DRAIN: assert `xrst` after 2 beats → `out_valid`, `busy`, `done` = 0 at once; after release, finish with no writes drains all zeros.

Source files
------------

// File: rtl/conv_result_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_result_drain_if
//  Description : Engine write port, finish pulse and downstream valid/ready
//                stream of the convolution result drain, bundled as one bus.
//  Revision    : 1.0  initial release
// ============================================================================
interface conv_result_drain_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic [AW-1:0]        y_waddr;
    logic signed [DW-1:0] y_wdata;
    logic                 y_wenable;
    logic                 conv_finish;
    logic [AW-1:0]        out_addr;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    // Engine / downstream side
    modport master (
        output y_waddr, y_wdata, y_wenable, conv_finish, out_ready,
        input  out_addr, out_data, out_valid, busy, done, overrun
    );

    // Drain block side
    modport slave (
        input  y_waddr, y_wdata, y_wenable, conv_finish, out_ready,
        output out_addr, out_data, out_valid, busy, done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/conv_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : conv_result_drain
//  Description : Captures one DEPTH-word result vector from the convolution
//                engine, then streams it in address order over valid/ready,
//                pulses done and rearms. Optional ReLU on the output path.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_result_drain #(
    parameter int DW   = 8,
    parameter int AW   = 2,
    parameter int RELU = 0
) (
    input  logic               clk,
    input  logic               xrst,
    conv_result_drain_if.slave bus
);
    localparam int c_DEPTH = 1 << AW;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               r_state;
    logic signed [DW-1:0] r_mem [c_DEPTH];
    logic [c_DEPTH-1:0]   r_written;
    logic [AW-1:0]        r_idx;
    logic [AW-1:0]        r_out_addr;
    logic signed [DW-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overrun;

    logic                 w_xfer;
    logic                 w_last;
    logic [AW-1:0]        w_next_idx;
    logic signed [DW-1:0] w_next_word;
    logic signed [DW-1:0] w_first_word;

    // ReLU is an output-only transform; storage always holds the raw word.
    function automatic logic signed [DW-1:0] relu_f(input logic signed [DW-1:0] v);
        logic signed [DW-1:0] r;
        r = v;
        if ((RELU != 0) && v[DW-1]) begin
            r = '0;
        end
        return r;
    endfunction

    // Beat bookkeeping and the word to present next; the first word bypasses
    // a same-cycle write to entry 0 so finish+write is captured correctly.
    always_comb begin
        w_xfer       = r_out_valid && bus.out_ready;
        w_last       = &r_idx;
        w_next_idx   = r_idx + 1'b1;
        w_next_word  = r_written[w_next_idx] ? r_mem[w_next_idx] : '0;
        w_first_word = r_written[0] ? r_mem[0] : '0;
        if (bus.y_wenable && (bus.y_waddr == '0)) begin
            w_first_word = bus.y_wdata;
        end
    end

    // Fill/drain state machine with storage and registered outputs.
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            r_state     <= FILL;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_written   <= '0;
            r_idx       <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FILL: begin
                    if (bus.y_wenable) begin
                        r_mem[bus.y_waddr]     <= bus.y_wdata;
                        r_written[bus.y_waddr] <= 1'b1;
                    end
                    if (bus.conv_finish) begin
                        r_state     <= DRAIN;
                        r_idx       <= '0;
                        r_out_addr  <= '0;
                        r_out_data  <= relu_f(w_first_word);
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Engine traffic here is a protocol error: flag it, drop it.
                    if (bus.y_wenable || bus.conv_finish) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state     <= FILL;
                            r_idx       <= '0;
                            r_out_addr  <= '0;
                            r_out_data  <= '0;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_written   <= '0;
                            for (int i = 0; i < c_DEPTH; i++) begin
                                r_mem[i] <= '0;
                            end
                        end else begin
                            r_idx      <= w_next_idx;
                            r_out_addr <= w_next_idx;
                            r_out_data <= relu_f(w_next_word);
                        end
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_result_drain
//  Description : Self-checking bench; drives a pass-through and a ReLU
//                instance with identical traffic and compares both against
//                a vector-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_result_drain;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic xrst;
    int   checks = 0;
    int   errors = 0;

    conv_result_drain_if #(.DW(DW), .AW(AW)) bus0 ();
    conv_result_drain_if #(.DW(DW), .AW(AW)) bus1 ();

    conv_result_drain #(.DW(DW), .AW(AW), .RELU(0)) dut0 (.clk(clk), .xrst(xrst), .bus(bus0.slave));
    conv_result_drain #(.DW(DW), .AW(AW), .RELU(1)) dut1 (.clk(clk), .xrst(xrst), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Reference model: the set of written entries of the current vector.
    logic signed [7:0] vec [int];
    bit                exp_ovr;

    function automatic logic signed [7:0] expect_word(input int a, input bit relu);
        logic signed [7:0] v;
        v = vec.exists(a) ? vec[a] : 8'sd0;
        if (relu && v < 0) v = 8'sd0;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit we, input int a, input logic signed [7:0] d, input bit fin, input bit rdy);
        bus0.y_wenable = we;  bus1.y_wenable = we;
        bus0.y_waddr = 2'(a); bus1.y_waddr = 2'(a);
        bus0.y_wdata = d;     bus1.y_wdata = d;
        bus0.conv_finish = fin; bus1.conv_finish = fin;
        bus0.out_ready = rdy; bus1.out_ready = rdy;
    endtask

    task automatic check_beat(input string tag, input int a);
        chk($sformatf("%s.valid0", tag), 32'(bus0.out_valid), 32'(1));
        chk($sformatf("%s.valid1", tag), 32'(bus1.out_valid), 32'(1));
        chk($sformatf("%s.busy0", tag), 32'(bus0.busy), 32'(1));
        chk($sformatf("%s.done0", tag), 32'(bus0.done), 32'(0));
        chk($sformatf("%s.addr0", tag), 32'(bus0.out_addr), 32'(a));
        chk($sformatf("%s.addr1", tag), 32'(bus1.out_addr), 32'(a));
        chk($sformatf("%s.data0[%0d]", tag, a), 32'(bus0.out_data), 32'(expect_word(a, 1'b0)));
        chk($sformatf("%s.data1[%0d]", tag, a), 32'(bus1.out_data), 32'(expect_word(a, 1'b1)));
        chk($sformatf("%s.ovr0", tag), 32'(bus0.overrun), 32'(exp_ovr));
    endtask

    task automatic check_idle(input string tag, input bit done_e);
        chk($sformatf("%s.valid0", tag), 32'(bus0.out_valid), 32'(0));
        chk($sformatf("%s.valid1", tag), 32'(bus1.out_valid), 32'(0));
        chk($sformatf("%s.busy0", tag), 32'(bus0.busy), 32'(0));
        chk($sformatf("%s.busy1", tag), 32'(bus1.busy), 32'(0));
        chk($sformatf("%s.done0", tag), 32'(bus0.done), 32'(done_e));
        chk($sformatf("%s.done1", tag), 32'(bus1.done), 32'(done_e));
        chk($sformatf("%s.ovr0", tag), 32'(bus0.overrun), 32'(exp_ovr));
        chk($sformatf("%s.ovr1", tag), 32'(bus1.overrun), 32'(exp_ovr));
    endtask

    task automatic fill_write(input int a, input logic signed [7:0] d);
        drive(1'b1, a, d, 1'b0, 1'b0);
        vec[a] = d;
        tick();
    endtask

    task automatic finish();
        drive(1'b0, 0, 8'sd0, 1'b1, 1'b0);
        tick();
    endtask

    // Called at the first cycle of DRAIN; walks all beats, then done and rearm.
    task automatic run_drain(input string tag, input int stall_addr, input int stall_n,
                             input bit rnd, input int inj, input bit done_wr);
        int a2;
        logic signed [7:0] d2;
        for (int a = 0; a < DEPTH; a++) begin
            int stalls;
            stalls = (a == stall_addr) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s <= stalls; s++) begin
                check_beat(tag, a);
                if (a == inj && s == 0) drive(1'b1, 0, 8'sd99, 1'b1, s == stalls);
                else                    drive(1'b0, 0, 8'sd0, 1'b0, s == stalls);
                tick();
                if (a == inj && s == 0) exp_ovr = 1'b1;
            end
        end
        check_idle({tag, ".done"}, 1'b1);
        vec.delete();
        if (done_wr) begin
            a2 = int'($urandom_range(0, DEPTH - 1));
            d2 = 8'($urandom);
            drive(1'b1, a2, d2, 1'b0, 1'b0);
            vec[a2] = d2;
        end else begin
            drive(1'b0, 0, 8'sd0, 1'b0, 1'b0);
        end
        tick();
        drive(1'b0, 0, 8'sd0, 1'b0, 1'b0);
        check_idle({tag, ".post"}, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_ovr = 1'b0;
        xrst = 1'b1;
        drive(1'b0, 0, 8'sd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        // Reset values
        check_idle("rst", 1'b0);
        chk("rst.addr0", 32'(bus0.out_addr), 32'(0));
        chk("rst.data0", 32'(bus0.out_data), 32'(0));
        xrst = 1'b0;
        tick();

        // Full vector, ready always high
        fill_write(0, 8'sd5);
        fill_write(1, -8'sd3);
        fill_write(2, 8'sd127);
        fill_write(3, -8'sd128);
        finish();
        run_drain("full", -1, 0, 1'b0, -1, 1'b0);

        // Backpressure on entry 1 for 3 cycles
        fill_write(0, 8'sd5);
        fill_write(1, -8'sd3);
        fill_write(2, 8'sd127);
        fill_write(3, -8'sd128);
        finish();
        run_drain("bp", 1, 3, 1'b0, -1, 1'b0);

        // Partial and overwritten writes, then an empty vector
        fill_write(2, 8'sd10);
        fill_write(2, 8'sd20);
        finish();
        run_drain("part", -1, 0, 1'b0, -1, 1'b0);
        finish();
        run_drain("empty", -1, 0, 1'b0, -1, 1'b0);

        // Negative, positive, most-negative and zero words
        fill_write(0, -8'sd1);
        fill_write(1, 8'sd4);
        fill_write(2, -8'sd128);
        fill_write(3, 8'sd0);
        finish();
        run_drain("relu", -1, 0, 1'b0, -1, 1'b0);

        // Randomized vectors: random writes, finish sometimes carrying a write,
        // random stalls, and a write landing in the done cycle
        for (int v = 0; v < 20; v++) begin
            int nw;
            nw = int'($urandom_range(0, 6));
            for (int w = 0; w < nw; w++) begin
                fill_write(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                int fa;
                logic signed [7:0] fd;
                fa = int'($urandom_range(0, DEPTH - 1));
                fd = 8'($urandom);
                drive(1'b1, fa, fd, 1'b1, 1'b0);
                vec[fa] = fd;
                tick();
            end else begin
                finish();
            end
            run_drain("rand", -1, 0, 1'b1, -1, v[0]);
        end
        vec.delete();

        // Overrun: write and finish during DRAIN are flagged and ignored
        fill_write(0, 8'sd5);
        fill_write(1, -8'sd3);
        fill_write(2, 8'sd127);
        fill_write(3, -8'sd128);
        finish();
        run_drain("ovr", -1, 0, 1'b0, 1, 1'b0);
        repeat (2) begin
            tick();
            check_idle("ovr.stay", 1'b0);
        end

        // Reset mid-DRAIN
        fill_write(1, 8'sd7);
        finish();
        drive(1'b0, 0, 8'sd0, 1'b0, 1'b1);
        check_beat("mid", 0);
        tick();
        check_beat("mid", 1);
        tick();
        xrst = 1'b1;
        #1;
        exp_ovr = 1'b0;
        vec.delete();
        check_idle("midrst", 1'b0);
        @(negedge clk);
        xrst = 1'b0;
        drive(1'b0, 0, 8'sd0, 1'b0, 1'b0);
        tick();
        check_idle("afterrst", 1'b0);
        finish();
        run_drain("zeros", -1, 0, 1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
